program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot-time loader directly upstream of the cpu top. Accepts a 32-bit word stream from a host link
//  (valid/ready), writes it into instruction memory through the cpu's addr_ext/wen_ext/wdata_ext port
//  and data memory through addr_ext_2/wen_ext_2/wdata_ext_2. It then raises cpu_enable to start execution.
//  Host halt or a new start returns the cpu to stopped.
// PARAMETERS
//  IMEM_DEPTH  128  max instruction words accepted (32-bit, byte address = 4*i)
//  DMEM_DEPTH  128  max data dwords accepted (64-bit, byte address = 8*i)
//  CNT_W       16   width of header count fields
// PORTS
//  clk          in   1   main clock
//  arst_n       in   1   asynchronous active-low reset
//  start        in   1   1-cycle pulse; begins a load (honoured in IDLE, RUN, ERR)
//  halt         in   1   in RUN: drop cpu_enable, go IDLE
//  s_valid      in   1   host word valid
//  s_data       in   32  host word
//  s_ready      out  1   loader accepts s_data this cycle
//  addr_ext     out  64  imem byte address
//  wen_ext      out  1   imem write strobe
//  ren_ext      out  1   imem read enable, tied 0
//  wdata_ext    out  32  imem write word
//  addr_ext_2   out  64  dmem byte address
//  wen_ext_2    out  1   dmem write strobe
//  ren_ext_2    out  1   dmem read enable, tied 0
//  wdata_ext_2  out  64  dmem write dword
//  cpu_enable   out  1   drives cpu enable
//  busy         out  1   high in HDR..FLUSH
//  error        out  1   high in ERR
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0, including addresses, data, s_ready and cpu_enable.
//  Beat = s_valid & s_ready. s_ready is combinational from state: 1 in HDR, IMEM, DMEM_LO, DMEM_HI.
//    s_ready is never dependent on s_valid.
//  States:
//   IDLE    start -> HDR. Clear the word counters.
//   HDR     on a beat: ni = s_data[15:0], nd = s_data[31:16].
//           ni>IMEM_DEPTH or nd>DMEM_DEPTH -> ERR.
//           Else ni!=0 -> IMEM; else nd!=0 -> DMEM_LO; else -> FLUSH.
//   IMEM    beat k (0-based): next cycle wen_ext=1 for exactly 1 cycle, addr_ext=4*k, wdata_ext=s_data.
//           On beat ni-1 -> DMEM_LO if nd!=0, else FLUSH.
//   DMEM_LO on a beat, latch s_data as low half -> DMEM_HI.
//   DMEM_HI on beat j: next cycle wen_ext_2=1 for 1 cycle, addr_ext_2=8*j,
//           wdata_ext_2={s_data, lo}. On the last j -> FLUSH, else -> DMEM_LO.
//   FLUSH   1 cycle, so the final write strobe completes before enable -> RUN.
//   RUN     cpu_enable=1 (registered; first high the cycle after FLUSH).
//           halt -> IDLE. start -> HDR. In both cases cpu_enable drops on the next edge.
//   ERR     error=1, cpu_enable=0, no writes. start -> HDR (error clears).
//  All strobes and address/data outputs are registered.
//  Write latency is 1 cycle from the accepting edge. At most one strobe is high per cycle.
//  Address/data hold their last values when the strobe is low.
//  Simultaneous start & halt in RUN: start wins.
//  start in HDR..FLUSH is ignored.
//  halt outside RUN is ignored.
//  s_valid with no s_ready: the word is not consumed, no write.
//  Counters are CNT_W bits. ni=IMEM_DEPTH is legal; IMEM_DEPTH+1 is an error.
//  Addresses zero-extend to 64 bits.
//  arst_n low at any point, including mid-load: immediate return to IDLE with all outputs 0.
//    A partial image stays in memory; the cpu stays disabled.
// STRUCTURE
//  Package loader_pkg:
//    state enum {IDLE,HDR,IMEM,DMEM_LO,DMEM_HI,FLUSH,RUN,ERR}
//    header field slices (NI_LSB=0, ND_LSB=16), byte strides (4, 8).
//  One sub-module, loader_beat_counter: CNT_W-bit counter with clear, increment on beat,
//    and an is_last = (cnt==limit-1) output. Instantiated twice (imem, dmem).
//  FSM, header registers and output registers stay in program_loader.
// TESTING
//  1) Header 0x0002_0003, imem words A,B,C, dmem words L0,H0,L1,H1 ->
//     wen_ext pulses at addr 0,4,8; wen_ext_2 {H0,L0}@0, {H1,L1}@8; cpu_enable rises 2 cycles after last beat.
//  2) Header 0x0000_0000 -> FLUSH then RUN; no write strobes.
//  3) Header 0x0000_0081 (ni=129) -> error=1, s_ready=0, no strobes.
//     Then start -> error=0, state HDR.
//  4) Random s_valid gaps (~50%) on case 1 -> identical write sequence;
//     no strobe without a preceding beat.
//  5) Assert arst_n low after the 2nd imem beat -> all outputs 0 asynchronously.
//     After release: IDLE, s_ready=0, cpu_enable=0.
//  6) In RUN, pulse halt and start together -> start wins:
//     cpu_enable low next cycle, state HDR, s_ready=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE, HDR, IMEM, DMEM_LO, DMEM_HI, FLUSH, RUN, ERR
    } state_t;

    // Header word layout: {nd, ni}
    localparam int NI_LSB      = 0;
    localparam int ND_LSB      = 16;
    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;

endpackage

// File: rtl/loader_beat_counter.sv
// Beat counter with synchronous clear; is_last flags the final beat of a limit-long run.
module loader_beat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             is_last
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)  cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc) cnt <= cnt + CNT_W'(1);
    end

    assign is_last = (cnt == limit - CNT_W'(1));

endmodule

// File: rtl/program_loader.sv
// Streams a header plus imem/dmem image from the host link into the cpu memories,
// then enables the cpu.
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 128,
    parameter int DMEM_DEPTH = 128,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        halt,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] ni_q, nd_q, icnt, dcnt;
    logic [CNT_W-1:0] hdr_ni, hdr_nd;
    logic [31:0]      lo_q;
    logic             beat, start_ok, i_last, d_last;

    assign s_ready  = (state == HDR) || (state == IMEM) || (state == DMEM_LO) || (state == DMEM_HI);
    assign beat     = s_valid && s_ready;
    assign start_ok = start && ((state == IDLE) || (state == RUN) || (state == ERR));
    assign hdr_ni   = s_data[NI_LSB +: CNT_W];
    assign hdr_nd   = s_data[ND_LSB +: CNT_W];
    assign ren_ext   = 1'b0;
    assign ren_ext_2 = 1'b0;

    loader_beat_counter #(.CNT_W(CNT_W)) u_icnt (
        .clk(clk), .arst_n(arst_n), .clr(start_ok),
        .inc(beat && (state == IMEM)), .limit(ni_q), .cnt(icnt), .is_last(i_last)
    );

    loader_beat_counter #(.CNT_W(CNT_W)) u_dcnt (
        .clk(clk), .arst_n(arst_n), .clr(start_ok),
        .inc(beat && (state == DMEM_HI)), .limit(nd_q), .cnt(dcnt), .is_last(d_last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = HDR;
            HDR: if (beat) begin
                if (hdr_ni > CNT_W'(IMEM_DEPTH) || hdr_nd > CNT_W'(DMEM_DEPTH)) state_nxt = ERR;
                else if (hdr_ni != '0) state_nxt = IMEM;
                else if (hdr_nd != '0) state_nxt = DMEM_LO;
                else                   state_nxt = FLUSH;
            end
            IMEM:    if (beat && i_last) state_nxt = (nd_q != '0) ? DMEM_LO : FLUSH;
            DMEM_LO: if (beat) state_nxt = DMEM_HI;
            DMEM_HI: if (beat) state_nxt = d_last ? FLUSH : DMEM_LO;
            FLUSH:   state_nxt = RUN;
            // start takes priority over halt
            RUN:     if (start) state_nxt = HDR;
                     else if (halt) state_nxt = IDLE;
            ERR:     if (start) state_nxt = HDR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            cpu_enable <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cpu_enable <= (state_nxt == RUN);
            busy       <= (state_nxt == HDR) || (state_nxt == IMEM) || (state_nxt == DMEM_LO) ||
                          (state_nxt == DMEM_HI) || (state_nxt == FLUSH);
            error      <= (state_nxt == ERR);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            ni_q <= '0;
            nd_q <= '0;
            lo_q <= '0;
        end else begin
            if (beat && state == HDR) begin
                ni_q <= hdr_ni;
                nd_q <= hdr_nd;
            end
            if (beat && state == DMEM_LO) lo_q <= s_data;
        end
    end

    // Write ports: strobe is a 1-cycle pulse, address/data hold otherwise
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wen_ext     <= 1'b0;
            addr_ext    <= '0;
            wdata_ext   <= '0;
            wen_ext_2   <= 1'b0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
        end else begin
            wen_ext   <= beat && (state == IMEM);
            wen_ext_2 <= beat && (state == DMEM_HI);
            if (beat && state == IMEM) begin
                addr_ext  <= 64'(icnt) * 64'(IMEM_STRIDE);
                wdata_ext <= s_data;
            end
            if (beat && state == DMEM_HI) begin
                addr_ext_2  <= 64'(dcnt) * 64'(DMEM_STRIDE);
                wdata_ext_2 <= {s_data, lo_q};
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as beats are offered.
module tb_program_loader;

    localparam int IMEM_DEPTH = 128;
    localparam int DMEM_DEPTH = 128;
    localparam int CNT_W      = 16;

    typedef struct {
        bit          dmem;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    logic        clk, arst_n, start, halt, s_valid, s_ready;
    logic [31:0] s_data, wdata_ext;
    logic [63:0] addr_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2, cpu_enable, busy, error;

    program_loader #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .halt(halt),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    wr_t         sb[$];
    logic [31:0] img_i[$];
    logic [31:0] img_d[$];
    wr_t         got;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued write
    always @(negedge clk) begin
        if (arst_n) begin
            if (wen_ext && wen_ext_2) chk("one_strobe", 1, 0);
            if (ren_ext || ren_ext_2) chk("ren_tied", 1, 0);
            if (wen_ext) begin
                if (sb.size() == 0) chk("imem_unexpected", 1, 0);
                else begin
                    got = sb.pop_front();
                    chk("imem_kind", 64'(got.dmem), 0);
                    chk("imem_addr", addr_ext, got.addr);
                    chk("imem_data", 64'(wdata_ext), got.data);
                end
            end
            if (wen_ext_2) begin
                if (sb.size() == 0) chk("dmem_unexpected", 1, 0);
                else begin
                    got = sb.pop_front();
                    chk("dmem_kind", 64'(got.dmem), 1);
                    chk("dmem_addr", addr_ext_2, got.addr);
                    chk("dmem_data", wdata_ext_2, got.data);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input bit push, input wr_t e, input bit gaps);
        bit done;
        int n;
        done = 0;
        n = 0;
        if (gaps)
            while ($urandom_range(1, 0) == 1 && n < 4) begin
                s_valid = 1'b0;
                @(negedge clk);
                n++;
            end
        s_valid = 1'b1;
        s_data  = d;
        n = 0;
        while (!done && n < 200) begin
            if (s_ready) begin
                done = 1;
                if (push) sb.push_back(e);
            end
            @(negedge clk);
            n++;
        end
        s_valid = 1'b0;
        if (!done) chk("beat_timeout", 0, 1);
    endtask

    task automatic load(input logic [31:0] hdr, input bit gaps);
        wr_t e;
        e.dmem = 0; e.addr = '0; e.data = '0;
        send_word(hdr, 0, e, gaps);
        foreach (img_i[k]) begin
            e.dmem = 0;
            e.addr = 64'(k * 4);
            e.data = 64'(img_i[k]);
            send_word(img_i[k], 1, e, gaps);
        end
        for (int j = 0; j < img_d.size() / 2; j++) begin
            send_word(img_d[2*j], 0, e, gaps);
            e.dmem = 1;
            e.addr = 64'(j * 8);
            e.data = {img_d[2*j+1], img_d[2*j]};
            send_word(img_d[2*j+1], 1, e, gaps);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (!cpu_enable && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("run_enable", 64'(cpu_enable), 1);
    endtask

    task automatic check_flush_then_run(input string tag);
        #1;
        chk({tag, "_sb_empty"}, 64'(sb.size()), 0);
        chk({tag, "_flush_en"}, 64'(cpu_enable), 0);
        chk({tag, "_flush_busy"}, 64'(busy), 1);
        @(negedge clk);
        chk({tag, "_run_en"}, 64'(cpu_enable), 1);
        chk({tag, "_run_busy"}, 64'(busy), 0);
    endtask

    task automatic set_case1();
        img_i = '{32'hA000_000A, 32'hB000_000B, 32'hC000_000C};
        img_d = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0001, 32'h4444_0001};
    endtask

    initial begin
        arst_n = 1'b0; start = 1'b0; halt = 1'b0; s_valid = 1'b0; s_data = '0;
        #12;
        chk("rst_s_ready", 64'(s_ready), 0);
        chk("rst_cpu_en", 64'(cpu_enable), 0);
        chk("rst_addr", addr_ext, 0);
        chk("rst_addr2", addr_ext_2, 0);
        chk("rst_wdata2", wdata_ext_2, 0);
        chk("rst_flags", {61'd0, busy, error, wen_ext | wen_ext_2}, 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // 1) basic image, plus halt ignored outside RUN
        pulse_start();
        chk("t1_hdr_ready", 64'(s_ready), 1);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("t1_halt_ignored", 64'(busy), 1);
        set_case1();
        load(32'h0002_0003, 0);
        check_flush_then_run("t1");

        // 2) empty image; start from RUN reloads
        pulse_start();
        chk("t2_en_drop", 64'(cpu_enable), 0);
        img_i = {}; img_d = {};
        load(32'h0000_0000, 0);
        check_flush_then_run("t2");

        // 3) oversize ni -> ERR, restart; then boundary ni=IMEM_DEPTH and oversize nd
        pulse_start();
        load(32'h0000_0081, 0);
        chk("t3_error", 64'(error), 1);
        chk("t3_ready", 64'(s_ready), 0);
        chk("t3_busy", 64'(busy), 0);
        chk("t3_en", 64'(cpu_enable), 0);
        s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        pulse_start();
        chk("t3_err_clear", 64'(error), 0);
        chk("t3_hdr_ready", 64'(s_ready), 1);
        chk("t3_hdr_busy", 64'(busy), 1);
        img_i = {};
        for (int k = 0; k < IMEM_DEPTH; k++) img_i.push_back($urandom);
        load(32'(IMEM_DEPTH), 0);
        check_flush_then_run("t3max");
        pulse_start();
        img_i = {};
        load(32'h0081_0000, 0);
        chk("t3_nd_error", 64'(error), 1);

        // 4) case 1 again with random valid gaps
        pulse_start();
        set_case1();
        img_d.push_back(32'h5555_0002);
        img_d.push_back(32'h6666_0002);
        load(32'h0003_0003, 1);
        #1 chk("t4_sb_empty", 64'(sb.size()), 0);
        wait_run();

        // 5) async reset mid-load after the second imem beat
        pulse_start();
        img_i = {32'h1234_5678, 32'h9ABC_DEF0};
        img_d = {};
        load(32'h0000_0004, 0);
        #2 arst_n = 1'b0;
        #1;
        chk("t5_addr", addr_ext, 0);
        chk("t5_wdata", 64'(wdata_ext), 0);
        chk("t5_ready", 64'(s_ready), 0);
        chk("t5_flags", {61'd0, busy, error, cpu_enable | wen_ext}, 0);
        chk("t5_sb_empty", 64'(sb.size()), 0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        chk("t5_post_ready", 64'(s_ready), 0);
        chk("t5_post_en", 64'(cpu_enable), 0);
        chk("t5_post_busy", 64'(busy), 0);

        // 6) start and halt together in RUN: start wins
        pulse_start();
        img_i = {}; img_d = {};
        load(32'h0000_0000, 0);
        wait_run();
        start = 1'b1; halt = 1'b1;
        @(negedge clk);
        start = 1'b0; halt = 1'b0;
        chk("t6_en_drop", 64'(cpu_enable), 0);
        chk("t6_busy", 64'(busy), 1);
        chk("t6_ready", 64'(s_ready), 1);
        load(32'h0000_0000, 0);
        wait_run();
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        chk("t6_halt_idle", {62'd0, cpu_enable, s_ready}, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
